// File: rtl/event_enc_pkg.sv
// event_enc_pkg: shared widths, types and helpers for the event encoder.
// Exports NUM_LINES, CODE_W, line_vec_t, code_t and onehot_of().
package event_enc_pkg;

   localparam int NUM_LINES = 8;
   localparam int CODE_W    = 3;

   typedef logic [NUM_LINES-1:0] line_vec_t;
   typedef logic [CODE_W-1:0]    code_t;

   function automatic line_vec_t onehot_of(code_t c);
      line_vec_t v;
      v    = '0;
      v[c] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/prio_enc_8x3.sv
// prio_enc_8x3: combinational highest-first search starting at start, with wrap.
// Ports: vec (candidates), start (first index tried), code (winner), any (vec != 0).
module prio_enc_8x3
   import event_enc_pkg::*;
(
   input  line_vec_t vec,
   input  code_t     start,
   output code_t     code,
   output logic      any
);

   code_t idx;

   // Walk downward from start; modulo-8 wrap falls out of the 3-bit subtract.
   always_comb begin
      code = '0;
      any  = 1'b0;
      idx  = '0;
      for (int i = 0; i < NUM_LINES; i++) begin
         idx = start - code_t'(i);
         if (!any && vec[idx]) begin
            any  = 1'b1;
            code = idx;
         end
      end
   end

endmodule

// File: rtl/event_encoder_8x3.sv
// event_encoder_8x3: captures req events into pending, emits 3-bit codes over valid/ready.
// Ports: clk, rst_n (async, low), req[7:0], code[2:0], valid, ready, pending[7:0], overflow.
// Build option: EVENT_ENC_ROUND_ROBIN_EN selects round-robin instead of fixed priority.
module event_encoder_8x3
   import event_enc_pkg::*;
#(
   parameter bit EDGE_DETECT = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] req,
   output logic [2:0] code,
   output logic       valid,
   input  logic       ready,
   output logic [7:0] pending,
   output logic       overflow
);

   line_vec_t rise;
   line_vec_t clr;
   code_t     start;
   code_t     sel;
   logic      sel_any;
   logic      load;
   logic      ovf_next;

   generate
      if (EDGE_DETECT) begin : g_edge
         line_vec_t req_q;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) req_q <= '0;
            else        req_q <= req;
         end

         assign rise = req & ~req_q;
      end else begin : g_level
         assign rise = req;
      end
   endgenerate

`ifdef EVENT_ENC_ROUND_ROBIN_EN
   code_t rr_ptr;

   // Resume just below the last emitted line so every line gets a turn.
   assign start = rr_ptr - 3'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)              rr_ptr <= '0;
      else if (load && sel_any) rr_ptr <= sel;
   end
`else
   assign start = 3'd7;
`endif

   prio_enc_8x3 u_prio (
      .vec   (pending),
      .start (start),
      .code  (sel),
      .any   (sel_any)
   );

   assign load = !valid || ready;

   always_comb begin
      clr = '0;
      if (load && sel_any) clr = onehot_of(sel);
   end

   // A new rise on a bit that stays pending merges into it and is lost.
   always_comb begin
      ovf_next = 1'b0;
      if (EDGE_DETECT) ovf_next = |(rise & pending & ~clr);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         code     <= '0;
         valid    <= 1'b0;
         pending  <= '0;
         overflow <= 1'b0;
      end else begin
         pending  <= (pending & ~clr) | rise;
         overflow <= ovf_next;
         if (load) begin
            valid <= sel_any;
            if (sel_any) code <= sel;
         end
      end
   end

endmodule

// File: tb/tb_event_encoder_8x3.sv
// tb_event_encoder_8x3: scoreboard bench with a cycle model of the encoder.
// Directed scenarios first, then randomized req/ready traffic.
module tb_event_encoder_8x3;

   logic       clk;
   logic       rst_n;
   logic [7:0] req;
   logic       ready;
   logic [2:0] code;
   logic       valid;
   logic [7:0] pending;
   logic       overflow;

   logic [7:0] req_l;
   logic       ready_l;
   logic [2:0] code_l;
   logic       valid_l;
   logic [7:0] pending_l;
   logic       overflow_l;

   int n_checks = 0;
   int n_pass   = 0;

   event_encoder_8x3 #(.EDGE_DETECT(1'b1)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req),
      .code     (code),
      .valid    (valid),
      .ready    (ready),
      .pending  (pending),
      .overflow (overflow)
   );

   event_encoder_8x3 #(.EDGE_DETECT(1'b0)) u_lvl (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req_l),
      .code     (code_l),
      .valid    (valid_l),
      .ready    (ready_l),
      .pending  (pending_l),
      .overflow (overflow_l)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   // Reference model of the edge-mode instance.
   bit [7:0] m_pend, m_reqq, m_rise, m_clr;
   bit       m_valid, m_ovf;
   int       m_last, m_pick;
   int       exp_q[$];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_pend  = '0;
         m_reqq  = '0;
         m_valid = 1'b0;
         m_ovf   = 1'b0;
         m_last  = 0;
         exp_q.delete();
      end else begin
         m_rise = req & ~m_reqq;
         m_reqq = req;
         m_clr  = '0;
         if (!m_valid || ready) begin
            m_pick = -1;
            for (int k = 1; k <= 8; k++) begin
               int idx;
`ifdef EVENT_ENC_ROUND_ROBIN_EN
               idx = (m_last - k + 16) % 8;
`else
               idx = 8 - k;
`endif
               if (m_pick < 0 && m_pend[idx]) m_pick = idx;
            end
            if (m_pick >= 0) begin
               m_valid        = 1'b1;
               m_clr[m_pick]  = 1'b1;
               m_last         = m_pick;
               exp_q.push_back(m_pick);
            end else begin
               m_valid = 1'b0;
            end
         end
         m_ovf  = |(m_rise & m_pend & ~m_clr);
         m_pend = (m_pend & ~m_clr) | m_rise;
      end
   end

   // Monitor: state compare each cycle, code compare on every handshake.
   always @(negedge clk) begin
      if (rst_n) begin
         check("valid", int'(valid), int'(m_valid));
         check("pending", int'(pending), int'(m_pend));
         check("overflow", int'(overflow), int'(m_ovf));
         if (valid && ready) begin
            if (exp_q.size() == 0) check("sb_underflow", 1, 0);
            else check("code", int'(code), exp_q.pop_front());
         end
      end
   end

   task automatic step(input logic [7:0] r, input logic rd);
      @(posedge clk);
      #1;
      req   = r;
      ready = rd;
   endtask

   task automatic mid_reset();
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("rst_valid", int'(valid), 0);
      check("rst_pending", int'(pending), 0);
      check("rst_overflow", int'(overflow), 0);
      check("rst_code", int'(code), 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      rst_n   = 1'b0;
      req     = '0;
      ready   = 1'b1;
      req_l   = '0;
      ready_l = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_code", int'(code), 0);
      check("reset_valid", int'(valid), 0);
      check("reset_pending", int'(pending), 0);
      check("reset_overflow", int'(overflow), 0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Single pulse: 2-cycle latency, code 5 for one cycle.
      step(8'h00, 1'b1);
      step(8'h20, 1'b1);
      step(8'h00, 1'b1);
      @(negedge clk);
      check("t1_pending", int'(pending), 8'h20);
      check("t1_valid_early", int'(valid), 0);
      step(8'h00, 1'b1);
      @(negedge clk);
      check("t1_valid", int'(valid), 1);
      check("t1_code", int'(code), 5);
      check("t1_pend_clr", int'(pending), 0);
      step(8'h00, 1'b1);
      @(negedge clk);
      check("t1_valid_drop", int'(valid), 0);
      check("t1_ovf", int'(overflow), 0);

      // Two lines at once: 7 then 0.
      step(8'h81, 1'b1);
      step(8'h00, 1'b1);
      step(8'h00, 1'b1);
      @(negedge clk);
      check("t2_code_a", int'(code), 7);
      step(8'h00, 1'b1);
      @(negedge clk);
      check("t2_code_b", int'(code), 0);
      check("t2_valid_b", int'(valid), 1);
      repeat (2) step(8'h00, 1'b1);

      // Backpressure: code 2 held, bit 4 pending.
      step(8'h04, 1'b0);
      step(8'h10, 1'b0);
      step(8'h00, 1'b0);
      step(8'h00, 1'b0);
      @(negedge clk);
      check("t3_hold_valid", int'(valid), 1);
      check("t3_hold_code", int'(code), 2);
      check("t3_hold_pend", int'(pending), 8'h10);
      step(8'h00, 1'b1);
      step(8'h00, 1'b1);
      @(negedge clk);
      check("t3_next_code", int'(code), 4);
      repeat (3) step(8'h00, 1'b1);

      // Second rise on an already pending line.
      step(8'h04, 1'b0);
      step(8'h00, 1'b0);
      step(8'h08, 1'b0);
      step(8'h00, 1'b0);
      step(8'h08, 1'b0);
      step(8'h00, 1'b0);
      @(negedge clk);
      check("t4_ovf_pulse", int'(overflow), 1);
      check("t4_pend", int'(pending), 8'h08);
      step(8'h00, 1'b0);
      @(negedge clk);
      check("t4_ovf_end", int'(overflow), 0);
      repeat (4) step(8'h00, 1'b1);

      // Level mode with a held request pair.
      @(posedge clk);
      #1 req_l = 8'h11;
      @(posedge clk);
      @(posedge clk);
      for (int i = 0; i < 4; i++) begin
         int exp_c;
`ifdef EVENT_ENC_ROUND_ROBIN_EN
         exp_c = (i % 2 == 0) ? 4 : 0;
`else
         exp_c = 4;
`endif
         @(negedge clk);
         check("t5_valid", int'(valid_l), 1);
         check("t5_code", int'(code_l), exp_c);
         check("t5_pend", int'(pending_l), 8'h11);
         check("t5_ovf", int'(overflow_l), 0);
         @(posedge clk);
      end
      #1 req_l = 8'h00;

      // Asynchronous reset while holding a code with all lines pending.
      step(8'h01, 1'b0);
      step(8'h00, 1'b0);
      step(8'hFF, 1'b0);
      step(8'h00, 1'b0);
      @(negedge clk);
      check("t6_pre_valid", int'(valid), 1);
      check("t6_pre_pend", int'(pending), 8'hFF);
      mid_reset();
      step(8'h00, 1'b1);

      // Random traffic with one reset in the middle.
      for (int n = 0; n < 1500; n++) begin
         step(8'($urandom & $urandom), $urandom_range(0, 3) != 0);
         if (n == 700) mid_reset();
      end

      repeat (20) step(8'h00, 1'b1);
      @(negedge clk);
      check("sb_drain", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/event_encoder_8x3.md
Name: event_encoder_8x3

Overview:
- Sequential 8-to-3 encoder; the return path for the 3-to-8 one-hot decoder.
- Captures events on 8 request lines into a pending register.
- Emits each event as a 3-bit binary code (x = MSB, z = LSB) through a valid/ready output stage.
- Sits between interrupt/event sources and a consumer that accepts one code per handshake.

Parameters:
- EDGE_DETECT, 1, 1 = a pending bit is set on a rising edge of req[i]; 0 = set every cycle req[i] is high (level mode).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous assert, active-low reset.
- req  input  8  event request lines; synchronous to clk.
- code  output  3  encoded index of the emitted event; code[2]=x, code[1]=y, code[0]=z.
- valid  output  1  code holds an event.
- ready  input  1  consumer accepts code when valid && ready.
- pending  output  8  pending register; read-only, for debug.
- overflow  output  1  one-cycle pulse: an event was lost because its bit was already pending.

Behaviour:
- Reset (rst_n low, asynchronous): code=3'd0, valid=0, pending=8'h00, overflow=0, req_q=8'h00, rr_ptr=3'd0.
- Event detect, EDGE_DETECT=1: rise = req & ~req_q, where req_q is req registered each cycle.
- Event detect, EDGE_DETECT=0: rise = req.
- Pending update at each edge: pending_next = (pending & ~clr) | rise.
  - clr is the one-hot bit loaded into the output stage this cycle.
  - If rise and clr hit the same bit, set wins; the bit stays pending for a second emission.
- Overflow:
  - overflow_next = |(rise & pending & ~clr).
  - Registered; high for exactly one cycle per detection edge.
  - Forced to 0 when EDGE_DETECT=0.
- Output stage is one register. Load condition: slot free = !valid || ready.
  - On load with pending != 0: code = selected index, valid = 1, clr = one-hot of that index.
  - On load with pending == 0: valid = 0, code holds its last value.
  - Holding (valid && !ready): code and valid are stable; pending keeps accumulating.
- Selection (fixed priority, default): the highest set index of pending wins (bit 7 highest).
- Selection sees only pending as registered; a rise in the same cycle is not eligible.
- Latency:
  - req first sampled high at edge k sets pending at edge k.
  - valid=1 after edge k+1 if the slot is free.
  - The minimum req-to-valid latency is 2 cycles.
- Throughput: one code per cycle while ready=1 and pending != 0.
- Back-to-back handshake: a handshake at edge n loads the next code at the same edge n; there is no bubble.
- Reset mid-operation: everything clears immediately, including any code being held under backpressure; no partial handshake survives.
- After reset deasserts in edge mode, a req line already high is detected as a rise (req_q=0).

Optional Feature:
- Macro: EVENT_ENC_ROUND_ROBIN_EN.
- Defined:
  - rr_ptr holds the last emitted code and updates on every load.
  - The search starts at (rr_ptr-1) mod 8 and proceeds downward with wrap.
  - Reset rr_ptr=0, so the first search starts at 7, identical to fixed priority.
- Undefined: fixed priority only; no rr_ptr register.

Decomposition:
- Package event_enc_pkg:
  - NUM_LINES=8, CODE_W=3.
  - typedef line_vec_t (8 bits), typedef code_t (3 bits).
  - Function onehot_of(code_t) returning line_vec_t.
- Sub-module prio_enc_8x3 (combinational):
  - Inputs vec[7:0] and start[2:0].
  - Outputs code[2:0] and any.
  - Performs a highest-first search beginning at start, with wrap.
- Fixed-priority mode drives start=7.

Test Plan:
- Reset with req=8'h00, ready=1, then pulse req=8'h20 for one cycle -> valid=1 two cycles later with code=3'd5 for one cycle; pending returns to 8'h00; overflow stays 0.
- req=8'h81 in one cycle, ready=1 -> code 7 then code 0 on consecutive cycles; with round robin, the same result.
- ready=0 while req pulses 8'h04 then 8'h10 -> valid=1 and code=3'd2 held stable; pending=8'h10. Raise ready -> code 2 accepted, code 4 next cycle.
- Bit 3 pending under ready=0, then a second rise on req[3] -> overflow pulses one cycle; pending=8'h08 unchanged; only one code 3 emitted.
- EVENT_ENC_ROUND_ROBIN_EN defined, req held so pending stays 8'h11 (EDGE_DETECT=0), ready=1 -> codes alternate 4,0,4,0; fixed-priority build emits only 4 repeatedly.
- Assert rst_n=0 mid-stream with valid=1 and pending=8'hFF -> valid, pending and overflow drop at once, before the next clk edge.
